// File: rtl/quadrilatero_pkg.sv
// Shared OBI definitions for the quadrilatero blocks: field widths and the
// byte-enable width derived from the data width.
package quadrilatero_pkg;

   localparam int unsigned ObiAddrWidth = 32;
   localparam int unsigned CountWidth   = 16;

   function automatic int unsigned obi_be_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/quadrilatero_obi_resp_pipe.sv
// Fixed-latency response delay line: RESP_LATENCY stages of {valid, err, rdata},
// cleared by synchronous reset so in-flight responses are dropped.
module quadrilatero_obi_resp_pipe #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned RESP_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic                  err_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  valid_o,
   output logic                  err_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [RESP_LATENCY-1:0] valid_q;
   logic [RESP_LATENCY-1:0] err_q;
   logic [DATA_WIDTH-1:0]   rdata_q [RESP_LATENCY];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < RESP_LATENCY; i++) begin
            rdata_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         err_q[0]   <= err_i;
         rdata_q[0] <= rdata_i;
         for (int i = 1; i < RESP_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            rdata_q[i] <= rdata_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[RESP_LATENCY-1];
   assign err_o   = err_q[RESP_LATENCY-1];
   assign rdata_o = rdata_q[RESP_LATENCY-1];

endmodule

// File: rtl/quadrilatero_obi_responder.sv
// OBI memory responder: single-port word array with byte-enabled writes,
// fixed-latency in-order responses, range errors and saturating access counters.
module quadrilatero_obi_responder
   import quadrilatero_pkg::*;
#(
   parameter int unsigned              DATA_WIDTH   = 32,
   parameter int unsigned              NUM_WORDS    = 256,
   parameter logic [ObiAddrWidth-1:0]  BASE_ADDR    = '0,
   parameter int unsigned              RESP_LATENCY = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  data_req_i,
   input  logic [ObiAddrWidth-1:0]               data_addr_i,
   input  logic                                  data_we_i,
   input  logic [obi_be_width(DATA_WIDTH)-1:0]   data_be_i,
   input  logic [DATA_WIDTH-1:0]                 data_wdata_i,
   output logic                                  data_gnt_o,
   output logic                                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0]                 data_rdata_o,
   output logic                                  data_err_o,
   input  logic                                  stall_i,
   output logic [CountWidth-1:0]                 rd_count_o,
   output logic [CountWidth-1:0]                 wr_count_o
);

   localparam int unsigned       BeWidth      = obi_be_width(DATA_WIDTH);
   localparam int unsigned       IdxWidth     = $clog2(NUM_WORDS);
   localparam int unsigned       ByteOffWidth = $clog2(BeWidth);
   localparam longint unsigned   MemBytes     = longint'(NUM_WORDS) * longint'(BeWidth);

   logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];
   logic [ObiAddrWidth-1:0] offset;
   logic [IdxWidth-1:0]     word_idx;
   logic                    in_range;
   logic                    txn;
   logic [DATA_WIDTH-1:0]   resp_rdata;
   logic                    pipe_valid;
   logic                    pipe_err;
   logic [DATA_WIDTH-1:0]   pipe_rdata;
   logic [CountWidth-1:0]   rd_count_d, rd_count_q;
   logic [CountWidth-1:0]   wr_count_d, wr_count_q;

   // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
   assign offset   = data_addr_i - BASE_ADDR;
   assign in_range = 64'(offset) < MemBytes;
   assign word_idx = offset[ByteOffWidth +: IdxWidth];

   assign data_gnt_o = data_req_i & ~stall_i & rst_ni;
   assign txn        = data_gnt_o;

   assign resp_rdata = (txn && !data_we_i && in_range) ? mem_q[word_idx] : '0;

   always_ff @(posedge clk_i) begin
      if (txn && data_we_i && in_range) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (data_be_i[b]) begin
               mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   quadrilatero_obi_resp_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .RESP_LATENCY (RESP_LATENCY)
   ) u_resp_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (txn),
      .err_i   (txn & ~in_range),
      .rdata_i (resp_rdata),
      .valid_o (pipe_valid),
      .err_o   (pipe_err),
      .rdata_o (pipe_rdata)
   );

   assign data_rvalid_o = pipe_valid;
   assign data_err_o    = pipe_valid & pipe_err;
   assign data_rdata_o  = pipe_valid ? pipe_rdata : '0;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (txn && !data_we_i && (rd_count_q != '1)) begin
         rd_count_d = rd_count_q + 1'b1;
      end
      if (txn && data_we_i && (wr_count_q != '1)) begin
         wr_count_d = wr_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count_o = rd_count_q;
   assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_quadrilatero_obi_responder.sv
// Directed bench: two responders (latency 1 and 3) share one stimulus stream;
// a vector table covers the single-cycle behaviour, hand sequences the rest.
module tb_quadrilatero_obi_responder;

   localparam logic [31:0] Base = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        stall;

   logic        gnt1, rv1, err1;
   logic [31:0] rd1;
   logic [15:0] rdc1, wrc1;
   logic        gnt3, rv3, err3;
   logic [31:0] rd3;
   logic [15:0] rdc3, wrc3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   quadrilatero_obi_responder #(
      .DATA_WIDTH   (32),
      .NUM_WORDS    (256),
      .BASE_ADDR    (Base),
      .RESP_LATENCY (1)
   ) u_dut1 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_req_i    (req),
      .data_addr_i   (addr),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_wdata_i  (wdata),
      .data_gnt_o    (gnt1),
      .data_rvalid_o (rv1),
      .data_rdata_o  (rd1),
      .data_err_o    (err1),
      .stall_i       (stall),
      .rd_count_o    (rdc1),
      .wr_count_o    (wrc1)
   );

   quadrilatero_obi_responder #(
      .DATA_WIDTH   (32),
      .NUM_WORDS    (256),
      .BASE_ADDR    (Base),
      .RESP_LATENCY (3)
   ) u_dut3 (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_req_i    (req),
      .data_addr_i   (addr),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_wdata_i  (wdata),
      .data_gnt_o    (gnt3),
      .data_rvalid_o (rv3),
      .data_rdata_o  (rd3),
      .data_err_o    (err3),
      .stall_i       (stall),
      .rd_count_o    (rdc3),
      .wr_count_o    (wrc3)
   );

   typedef struct {
      logic        req;
      logic        stall;
      logic        we;
      logic [31:0] off;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        gnt;
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic r, input logic s, input logic w,
                               input logic [31:0] o, input logic [3:0] b,
                               input logic [31:0] wd, input logic g, input logic v,
                               input logic e, input logic [31:0] d);
      vec_t t;
      t.req = r; t.stall = s; t.we = w; t.off = o; t.be = b; t.wdata = wd;
      t.gnt = g; t.rvalid = v; t.err = e; t.rdata = d;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, then settle for sampling.
   task automatic drive(input logic r, input logic q, input logic s, input logic w,
                        input logic [31:0] o, input logic [3:0] b, input logic [31:0] wd);
      @(negedge clk);
      rst_n = r; req = q; stall = s; we = w; addr = Base + o; be = b; wdata = wd;
      #2;
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; stall = 1'b0; we = 1'b0;
      addr = Base; be = 4'h0; wdata = 32'h0;

      //          req  stl  we   off            be    wdata          gnt  rv   err  rdata
      vecs[0]  = mk(1, 0, 1, 32'h10,       4'hF, 32'hDEADBEEF, 1, 0, 0, 32'h0);
      vecs[1]  = mk(1, 0, 1, 32'h00,       4'hF, 32'h5A5A5A5A, 1, 1, 0, 32'h0);
      vecs[2]  = mk(1, 0, 0, 32'h10,       4'hF, 32'h0,        1, 1, 0, 32'h0);
      vecs[3]  = mk(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'hDEADBEEF);
      vecs[4]  = mk(1, 0, 1, 32'h20,       4'hF, 32'h11223344, 1, 0, 0, 32'h0);
      vecs[5]  = mk(1, 0, 1, 32'h20,       4'h5, 32'hAABBCCDD, 1, 1, 0, 32'h0);
      vecs[6]  = mk(1, 0, 0, 32'h20,       4'h3, 32'h0,        1, 1, 0, 32'h0);
      vecs[7]  = mk(1, 0, 0, 32'h400,      4'hF, 32'h0,        1, 1, 0, 32'h11BB33DD);
      vecs[8]  = mk(1, 0, 1, 32'h400,      4'hF, 32'hFFFFFFFF, 1, 1, 1, 32'h0);
      vecs[9]  = mk(1, 0, 0, 32'h01,       4'hF, 32'h0,        1, 1, 1, 32'h0);
      vecs[10] = mk(1, 1, 0, 32'h10,       4'hF, 32'h0,        0, 1, 0, 32'h5A5A5A5A);
      vecs[11] = mk(1, 1, 0, 32'h10,       4'hF, 32'h0,        0, 0, 0, 32'h0);
      vecs[12] = mk(1, 0, 0, 32'h10,       4'hF, 32'h0,        1, 0, 0, 32'h0);
      vecs[13] = mk(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'hDEADBEEF);
      vecs[14] = mk(1, 0, 0, 32'hFFFFFFFC, 4'hF, 32'h0,        1, 0, 0, 32'h0);
      vecs[15] = mk(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0);

      // Reset with a request pending: never granted.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
      chk("rst gnt1", 32'(gnt1), 32'h0);
      chk("rst gnt3", 32'(gnt3), 32'h0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
      chk("rst rvalid1", 32'(rv1), 32'h0);
      chk("rst rvalid3", 32'(rv3), 32'h0);
      chk("rst rdata1", rd1, 32'h0);
      chk("rst err1", 32'(err1), 32'h0);
      chk("rst rdcount", 32'(rdc1), 32'h0);
      chk("rst wrcount", 32'(wrc1), 32'h0);

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vecs[i].req, vecs[i].stall, vecs[i].we, vecs[i].off, vecs[i].be,
               vecs[i].wdata);
         chk($sformatf("vec%0d gnt", i), 32'(gnt1), 32'(vecs[i].gnt));
         chk($sformatf("vec%0d rvalid", i), 32'(rv1), 32'(vecs[i].rvalid));
         chk($sformatf("vec%0d err", i), 32'(err1), 32'(vecs[i].err));
         chk($sformatf("vec%0d rdata", i), rd1, vecs[i].rdata);
      end
      idle();
      chk("table rdcount", 32'(rdc1), 32'd6);
      chk("table wrcount", 32'(wrc1), 32'd5);
      for (int i = 0; i < 3; i++) idle();

      // Latency 3: eight back-to-back reads.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40 + 32'(4*i), 4'hF, 32'hC0DE0000 + 32'(i));
         chk($sformatf("fill%0d gnt3", i), 32'(gnt3), 32'h1);
      end
      for (int i = 0; i < 3; i++) idle();
      for (int c = 0; c < 12; c++) begin
         if (c < 8) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40 + 32'(4*c), 4'hF, 32'h0);
         else idle();
         if (c < 8) chk($sformatf("b2b c%0d gnt3", c), 32'(gnt3), 32'h1);
         chk($sformatf("b2b c%0d rvalid3", c), 32'(rv3), 32'(c >= 3 && c <= 10));
         chk($sformatf("b2b c%0d rdata3", c), rd3,
             (c >= 3 && c <= 10) ? 32'hC0DE0000 + 32'(c - 3) : 32'h0);
         chk($sformatf("b2b c%0d rvalid1", c), 32'(rv1), 32'(c >= 1 && c <= 8));
         chk($sformatf("b2b c%0d rdata1", c), rd1,
             (c >= 1 && c <= 8) ? 32'hC0DE0000 + 32'(c - 1) : 32'h0);
      end
      chk("b2b rdcount3", 32'(rdc3), 32'd14);
      chk("b2b wrcount3", 32'(wrc3), 32'd13);

      // Stall held five cycles while an earlier read is still in flight.
      for (int c = 0; c < 10; c++) begin
         if (c == 0) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
         else if (c <= 6) drive(1'b1, 1'b1, (c <= 5), 1'b0, 32'h44, 4'hF, 32'h0);
         else idle();
         chk($sformatf("stall c%0d gnt3", c), 32'(gnt3), 32'(c == 0 || c == 6));
         chk($sformatf("stall c%0d rvalid3", c), 32'(rv3), 32'(c == 3 || c == 9));
         chk($sformatf("stall c%0d rdata3", c), rd3,
             (c == 3) ? 32'hC0DE0000 : (c == 9) ? 32'hC0DE0001 : 32'h0);
         chk($sformatf("stall c%0d rvalid1", c), 32'(rv1), 32'(c == 1 || c == 7));
      end

      // Reset with two reads in flight.
      for (int c = 0; c < 12; c++) begin
         if (c < 2) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h48 + 32'(4*c), 4'hF, 32'h0);
         else if (c == 2) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h48, 4'hF, 32'h0);
         else if (c == 7) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 4'hF, 32'h0);
         else idle();
         if (c == 2) begin
            chk("midrst gnt1", 32'(gnt1), 32'h0);
            chk("midrst gnt3", 32'(gnt3), 32'h0);
         end
         if (c == 3) begin
            chk("midrst rdcount", 32'(rdc3), 32'h0);
            chk("midrst wrcount", 32'(wrc3), 32'h0);
         end
         if (c >= 3) begin
            chk($sformatf("midrst c%0d rvalid1", c), 32'(rv1), 32'(c == 8));
            chk($sformatf("midrst c%0d rdata1", c), rd1, (c == 8) ? 32'hC0DE0002 : 32'h0);
            chk($sformatf("midrst c%0d rvalid3", c), 32'(rv3), 32'(c == 10));
            chk($sformatf("midrst c%0d rdata3", c), rd3, (c == 10) ? 32'hC0DE0002 : 32'h0);
         end
      end
      chk("post rdcount", 32'(rdc1), 32'd1);
      chk("post wrcount", 32'(wrc1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/quadrilatero_obi_responder.md
QUADRILATERO_OBI_RESPONDER -- requirements
Module: quadrilatero_obi_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: OBI data width, multiple of 8.
REQ-002 SHALL have parameter NUM_WORDS, default 256: memory depth in words, power of 2.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0: byte address of word 0, aligned to NUM_WORDS*DATA_WIDTH/8.
REQ-004 SHALL have parameter RESP_LATENCY, default 1: cycles from grant to rvalid; legal range 1..4.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port data_req_i  input  1  OBI request valid.
REQ-008 SHALL have port data_addr_i  input  32  byte address.
REQ-009 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port data_be_i  input  DATA_WIDTH/8  byte enables.
REQ-011 SHALL have port data_wdata_i  input  DATA_WIDTH  write data.
REQ-012 SHALL have port data_gnt_o  output  1  request accepted this cycle.
REQ-013 SHALL have port data_rvalid_o  output  1  response valid.
REQ-014 SHALL have port data_rdata_o  output  DATA_WIDTH  read data.
REQ-015 SHALL have port data_err_o  output  1  response error, qualified by data_rvalid_o.
REQ-016 SHALL have port stall_i  input  1  backpressure injection; forces grant low.
REQ-017 SHALL have port rd_count_o  output  16  accepted reads, saturating.
REQ-018 SHALL have port wr_count_o  output  16  accepted writes, saturating.

Function
REQ-019 SHALL assert data_gnt_o combinationally = data_req_i & ~stall_i & ~rst-pending; at most one grant per cycle.
REQ-020 SHALL treat a cycle with data_req_i & data_gnt_o as a transaction; address, we, be, wdata sampled that cycle only.
REQ-021 SHALL compute word index = (data_addr_i - BASE_ADDR) >> log2(DATA_WIDTH/8); low address bits ignored.
REQ-022 SHALL flag out-of-range when (data_addr_i - BASE_ADDR) unsigned >= NUM_WORDS*DATA_WIDTH/8.
REQ-023 SHALL perform an in-range write in the grant cycle, updating only bytes with data_be_i set.
REQ-024 SHALL sample read data in the grant cycle, full word regardless of data_be_i; write in cycle N then read in N+1 returns the new data.
REQ-025 SHALL assert data_rvalid_o exactly RESP_LATENCY cycles after each grant, one pulse per transaction, in order, for reads and writes alike.
REQ-026 SHALL accept back-to-back grants every cycle; up to RESP_LATENCY responses in flight, no throughput loss.
REQ-027 SHALL drive data_rdata_o = read word on read responses, all zeros on write and error responses, all zeros when data_rvalid_o low.
REQ-028 SHALL, for out-of-range transactions, grant normally, suppress the write, and respond with data_err_o=1 and rdata zero.
REQ-029 SHALL increment rd_count_o/wr_count_o on the grant cycle (errors included), saturating at 16'hFFFF.
REQ-030 SHALL hold data_gnt_o low while stall_i=1; in-flight responses still emerge on schedule.

Reset
REQ-031 SHALL, on rst_ni low at a clock edge, clear the response pipeline, data_rvalid_o, data_err_o, data_rdata_o, and both counters to 0.
REQ-032 SHALL drop any in-flight responses on reset mid-operation; no rvalid in the first cycle after release.
REQ-033 SHALL hold data_gnt_o low during any cycle with rst_ni low.
REQ-034 SHALL leave memory contents unchanged by reset; the array has no reset.

Structure
REQ-035 SHALL take the OBI request/response field widths and byte-enable width function from shared package quadrilatero_pkg.
REQ-036 SHALL implement the response delay as sub-module quadrilatero_obi_resp_pipe: a RESP_LATENCY-stage shift register of {valid, err, rdata}.
REQ-037 SHALL infer the storage as one single-port array of NUM_WORDS x DATA_WIDTH.

Verification
REQ-038 SHALL cover: write 0xDEADBEEF at BASE+0x10, be=4'hF, then read 0x10 -> rvalid 1 cycle after each grant, rdata 0xDEADBEEF, err 0.
REQ-039 SHALL cover: write 0x11223344 then 0xAABBCCDD with be=4'b0101 at the same address, then read -> 0x11BB33DD.
REQ-040 SHALL cover: RESP_LATENCY=3, 8 back-to-back reads -> 8 grants in 8 cycles, rvalids in cycles 3..10, data in issue order.
REQ-041 SHALL cover: read at BASE+0x400 with NUM_WORDS=256 -> granted, err=1, rdata 0, memory unchanged.
REQ-042 SHALL cover: stall_i high for 5 cycles with req held -> no grant for 5 cycles, grant in the 6th, a pending earlier rvalid still on time.
REQ-043 SHALL cover: reset asserted with 2 reads in flight -> no rvalid afterwards, counters 0, memory data preserved on re-read.
